// File: rtl/map_query_arbiter_if.sv
// Bundle between the wall-query movers/renderer (master) and the map query arbiter (slave).
// It also carries the two combinational map ROM ports.
interface map_query_arbiter_if #(parameter int N_REQ = 5);
    logic [N_REQ-1:0]   req;
    logic [5*N_REQ-1:0] req_x;
    logic [5*N_REQ-1:0] req_y;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   wall;
    logic               render_en;
    logic [4:0]         render_row;
    logic [31:0]        render_data;
    logic               render_valid;
    logic [4:0]         map_addr_a;
    logic [4:0]         map_addr_b;
    logic [31:0]        map_row_a;
    logic [31:0]        map_row_b;

    modport master (
        output req, req_x, req_y, render_en, render_row, map_row_a, map_row_b,
        input  ack, wall, render_data, render_valid, map_addr_a, map_addr_b
    );

    modport slave (
        input  req, req_x, req_y, render_en, render_row, map_row_a, map_row_b,
        output ack, wall, render_data, render_valid, map_addr_a, map_addr_b
    );
endinterface

// File: rtl/map_query_arbiter.sv
// Round-robin sharing of the two map ROM read ports among N_REQ wall queries.
// Port A goes to the renderer while render_en is high.
module map_query_lane (
    input  logic        clk,
    input  logic        reset,
    input  logic        gnt_a,
    input  logic        gnt_b,
    input  logic [4:0]  x,
    input  logic [31:0] row_a,
    input  logic [31:0] row_b,
    output logic        grant_q,
    output logic        wall
);
    // Column 0 sits in the MSB, so the bit index is 31 - x, which is ~x.
    logic [4:0] col;
    assign col = ~x;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= 1'b0;
            wall    <= 1'b0;
        end else begin
            grant_q <= gnt_a | gnt_b;
            if (gnt_a)      wall <= row_a[col];
            else if (gnt_b) wall <= row_b[col];
        end
    end
endmodule

module map_query_arbiter #(
    parameter int N_REQ = 5
) (
    input  logic               clk,
    input  logic               reset,
    map_query_arbiter_if.slave bus
);
    localparam int PW = 3;

    logic [PW-1:0]          rr_ptr;
    logic [N_REQ-1:0]       grant_q;
    logic [N_REQ-1:0]       wall_q;
    logic [N_REQ-1:0]       eligible;
    logic [N_REQ-1:0]       gnt_a;
    logic [N_REQ-1:0]       gnt_b;
    logic                   hit_a;
    logic                   hit_b;
    logic [PW-1:0]          idx_a;
    logic [PW-1:0]          idx_b;
    logic [PW:0]            cand;
    logic [PW:0]            nxt_ptr;
    logic [N_REQ-1:0][4:0]  req_x_v;
    logic [N_REQ-1:0][4:0]  req_y_v;
    logic [31:0]            row_a;
    logic [31:0]            row_b;

    assign req_x_v = bus.req_x;
    assign req_y_v = bus.req_y;
    assign row_a   = bus.map_row_a;
    assign row_b   = bus.map_row_b;

    // A requester in its ack cycle is masked so it cannot be granted twice.
    assign eligible = bus.req & ~grant_q;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx_a = '0;
        idx_b = '0;
        cand  = '0;
        if (!reset) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = {1'b0, rr_ptr} + (PW+1)'(k);
                if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
                if (eligible[cand[PW-1:0]]) begin
                    if (!bus.render_en && !hit_a) begin
                        hit_a = 1'b1;
                        idx_a = cand[PW-1:0];
                    end else if (!hit_b) begin
                        hit_b = 1'b1;
                        idx_b = cand[PW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        if (hit_a) gnt_a[idx_a] = 1'b1;
        if (hit_b) gnt_b[idx_b] = 1'b1;
    end

    // Port B always holds the later hit in scan order, so it is the last grant.
    always_comb begin
        nxt_ptr = {1'b0, (hit_b ? idx_b : idx_a)} + 1'b1;
        if (nxt_ptr >= (PW+1)'(N_REQ)) nxt_ptr = '0;
    end

    always_comb begin
        bus.map_addr_a = '0;
        bus.map_addr_b = '0;
        if (!reset) begin
            if (bus.render_en) bus.map_addr_a = bus.render_row;
            else if (hit_a)    bus.map_addr_a = req_y_v[idx_a];
            if (hit_b)         bus.map_addr_b = req_y_v[idx_b];
        end
    end

    map_query_lane u_lane [N_REQ-1:0] (
        .clk     (clk),
        .reset   (reset),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .x       (req_x_v),
        .row_a   (row_a),
        .row_b   (row_b),
        .grant_q (grant_q),
        .wall    (wall_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr           <= '0;
            bus.render_data  <= '0;
            bus.render_valid <= 1'b0;
        end else begin
            if (hit_a || hit_b) rr_ptr <= nxt_ptr[PW-1:0];
            if (bus.render_en) bus.render_data <= row_a;
            bus.render_valid <= bus.render_en;
        end
    end

    assign bus.ack  = grant_q;
    assign bus.wall = wall_q;
endmodule

// File: tb/tb_map_query_arbiter.sv
// Scoreboard bench for map_query_arbiter.
// Stimulus pushes expected answers per requester, and a negedge monitor pops them on each ack.
module tb_map_query_arbiter;
    localparam int N = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    map_query_arbiter_if #(.N_REQ(N)) bus ();
    map_query_arbiter #(.N_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    bit          wq [N][$];
    logic [31:0] rq [$];
    int          got_order [$];

    function automatic logic [31:0] rom(input logic [4:0] r);
        case (r)
            5'd2:    return 32'hF000C003;
            5'd6:    return 32'hF0000003;
            default: return {r, r, r, r, r, r, 2'b01};
        endcase
    endfunction

    assign bus.map_row_a = rom(bus.map_addr_a);
    assign bus.map_row_b = rom(bus.map_addr_b);

    function automatic bit wexp(input int x, input int y);
        logic [31:0] r;
        r = rom(5'(y));
        return r[31-x];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit on, input int x, input int y);
        bus.req[i]         = on;
        bus.req_x[5*i +: 5] = 5'(x);
        bus.req_y[5*i +: 5] = 5'(y);
    endtask

    task automatic issue(input int i, input int x, input int y);
        set_req(i, 1'b1, x, y);
        wq[i].push_back(wexp(x, y));
    endtask

    // Monitor: every ack must match a queued answer; wall must hold otherwise.
    initial begin
        logic [N-1:0] last_wall;
        bit e;
        last_wall = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_wall = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (bus.ack[i] === 1'b1) begin
                        checks++;
                        if (wq[i].size() == 0) begin
                            errors++;
                            $display("FAIL ack_unexpected[%0d] got ack=1 exp ack=0", i);
                        end else begin
                            e = wq[i].pop_front();
                            if (bus.wall[i] !== e) begin
                                errors++;
                                $display("FAIL wall[%0d] got %b exp %b", i, bus.wall[i], e);
                            end
                        end
                        got_order.push_back(i);
                    end else begin
                        checks++;
                        if (bus.wall[i] !== last_wall[i]) begin
                            errors++;
                            $display("FAIL wall_hold[%0d] got %b exp %b", i, bus.wall[i], last_wall[i]);
                        end
                    end
                end
                last_wall = bus.wall;
                if (bus.render_valid !== 1'b0) begin
                    checks++;
                    if (rq.size() == 0) begin
                        errors++;
                        $display("FAIL render_unexpected got valid=%b exp 0", bus.render_valid);
                    end else begin
                        logic [31:0] d;
                        d = rq.pop_front();
                        if (bus.render_data !== d) begin
                            errors++;
                            $display("FAIL render_data got %h exp %h", bus.render_data, d);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        bus.req        = '1;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.render_en  = 1'b0;
        bus.render_row = '0;

        // Reset held with everyone requesting.
        repeat (3) begin
            tick();
            check("rst_outs", {bus.ack, bus.wall, bus.render_valid, bus.map_addr_a, bus.map_addr_b}, 32'd0);
        end
        bus.req = '0;
        reset   = 1'b0;
        tick();

        // Single requester on port A, then new coords after the ack.
        issue(0, 3, 2);
        #1 check("single_addr_a", 32'(bus.map_addr_a), 32'd2);
        tick();
        tick();
        issue(0, 4, 2);
        #1 check("single2_addr_a", 32'(bus.map_addr_a), 32'd2);
        tick();
        bus.req[0] = 1'b0;
        tick();

        // The renderer reads row 2.
        bus.render_en  = 1'b1;
        bus.render_row = 5'd2;
        rq.push_back(32'hF000C003);
        #1 check("render_addr_a", 32'(bus.map_addr_a), 32'd2);
        tick();
        bus.render_en = 1'b0;
        tick();
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Two requesters are served together on ports A and B.
        issue(0, 4, 6);
        issue(1, 3, 6);
        #1 check("pair_addr_a", 32'(bus.map_addr_a), 32'd6);
        check("pair_addr_b", 32'(bus.map_addr_b), 32'd6);
        tick();
        check("pair_ack", 32'(bus.ack[1:0]), 32'd3);
        bus.req = '0;
        tick();
        // rr_ptr is 2 now: requester 2 wins port A over requester 0.
        issue(0, 0, 1);
        issue(2, 0, 3);
        #1 check("rr_addr_a", 32'(bus.map_addr_a), 32'd3);
        check("rr_addr_b", 32'(bus.map_addr_b), 32'd1);
        tick();
        bus.req = '0;
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;

        // All requesting with the renderer on: one grant per cycle on port B.
        got_order.delete();
        bus.render_en  = 1'b1;
        bus.render_row = 5'd6;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2*i+1, i+2);
        for (int k = 0; k < 6; k++) wq[k % N].push_back(wexp(2*(k%N)+1, (k%N)+2));
        for (int k = 0; k < 6; k++) begin
            #1 check("rr_all_addr_b", 32'(bus.map_addr_b), 32'((k % N) + 2));
            check("rr_all_addr_a", 32'(bus.map_addr_a), 32'd6);
            rq.push_back(32'hF0000003);
            tick();
        end
        bus.req       = '0;
        bus.render_en = 1'b0;
        tick();
        tick();
        check("order_len", 32'(got_order.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            if (k < got_order.size()) check("order", 32'(got_order[k]), 32'(k % N));

        // A reset arriving in the ack cycle drops the answer and clears rr_ptr.
        set_req(0, 1'b1, 0, 2);
        tick();
        reset = 1'b1;
        tick();
        check("rst_drop", {bus.ack, bus.wall, bus.map_addr_a, bus.map_addr_b}, 32'd0);
        reset = 1'b0;
        issue(0, 0, 2);
        issue(1, 0, 6);
        #1 check("rst_regrant_a", 32'(bus.map_addr_a), 32'd2);
        check("rst_regrant_b", 32'(bus.map_addr_b), 32'd6);
        tick();
        bus.req = '0;
        tick();
        tick();

        for (int i = 0; i < N; i++) check("drain_wq", 32'(wq[i].size()), 32'd0);
        check("drain_rq", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
